// File: rtl/motor_reg_file_gen2_if.sv
// Host bus bundle for motor_reg_file_gen2.
// master: host bridge side (drives address/strobes/write data).
// slave : register file side (returns registered read data and valid).
//   address   host address, ADDR_W bits
//   write_en  one-cycle write strobe
//   wr_data   write data byte
//   read_en   one-cycle read strobe
//   rd_data   registered read data
//   rd_valid  high the cycle after read_en
interface motor_reg_file_gen2_if #(
    parameter int ADDR_W = 7
) ();
    logic [ADDR_W-1:0] address;
    logic              write_en;
    logic [7:0]        wr_data;
    logic              read_en;
    logic [7:0]        rd_data;
    logic              rd_valid;

    modport master (
        output address, write_en, wr_data, read_en,
        input  rd_data, rd_valid
    );

    modport slave (
        input  address, write_en, wr_data, read_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/motor_reg_file_gen2.sv
// Parametrised motor subsystem register file.
// Decodes host accesses into drive/rotation/servo control registers, captures
// sticky motor faults (W1C), provides atomic 12-bit angle reads through a
// per-channel shadow nibble, commits target angles only on TARG_LO writes, and
// runs a host-link watchdog that, like e-stop, forces brakes on and enables off.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   bus             host register bus (slave modport)
//   fault           motor fault inputs, drives first then rotations
//   adc_temp        packed 7-bit motor temperatures (same channel order)
//   current_angle   packed 12-bit rotation angles
//   drive_ctrl      packed {brake,enable,direction,pwm[4:0]} per drive (registered)
//   rot_ctrl        packed {brake,enable,direction} per rotation (registered)
//   target_angle    packed committed 12-bit target angles
//   servo_position  packed servo positions
//   wdog_tripped    watchdog trip flag
//   irq             registered OR of unmasked sticky faults and wdog_tripped
module motor_reg_file_gen2 #(
    parameter int NUM_DRIVE  = 4,
    parameter int NUM_ROT    = 4,
    parameter int NUM_SERVO  = 4,
    parameter int ADDR_W     = 7,
    parameter int WDOG_W     = 24,
    parameter int WDOG_LIMIT = 5000000
) (
    input  logic                              clock,
    input  logic                              reset,
    motor_reg_file_gen2_if.slave              bus,
    input  logic [NUM_DRIVE+NUM_ROT-1:0]      fault,
    input  logic [7*(NUM_DRIVE+NUM_ROT)-1:0]  adc_temp,
    input  logic [12*NUM_ROT-1:0]             current_angle,
    output logic [8*NUM_DRIVE-1:0]            drive_ctrl,
    output logic [3*NUM_ROT-1:0]              rot_ctrl,
    output logic [12*NUM_ROT-1:0]             target_angle,
    output logic [8*NUM_SERVO-1:0]            servo_position,
    output logic                              wdog_tripped,
    output logic                              irq
);
    localparam int NUM_M = NUM_DRIVE + NUM_ROT;
    localparam int RB    = 8 + 2 * NUM_DRIVE;
    localparam int SB    = RB + 4 * NUM_ROT;
    localparam logic [7:0]        ID_VAL   = {4'(NUM_DRIVE), 4'(NUM_ROT)};
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT - 1);

    // Register state
    logic [7:0]               drive_reg_r [NUM_DRIVE];
    logic [7:0]               rot_reg_r   [NUM_ROT];
    logic [3:0]               shadow_r    [NUM_ROT];
    logic [12*NUM_ROT-1:0]    target_r;
    logic [8*NUM_SERVO-1:0]   servo_r;
    logic [NUM_M-1:0]         sticky_r;
    logic [NUM_M-1:0]         mask_r;
    logic                     wdog_en_r;
    logic                     estop_r;
    logic                     wdog_tripped_r;
    logic [WDOG_W-1:0]        wdog_cnt_r;
    logic                     irq_r;
    logic [7:0]               rd_data_r;
    logic                     rd_valid_r;
    logic [8*NUM_DRIVE-1:0]   drive_out_r;
    logic [3*NUM_ROT-1:0]     rot_out_r;

    // Decode and datapath
    logic [NUM_DRIVE-1:0]     wr_drive_s;
    logic [NUM_ROT-1:0]       wr_rot_ctrl_s;
    logic [NUM_ROT-1:0]       wr_targ_s;
    logic [NUM_ROT-1:0]       rd_curr_lo_s;
    logic [NUM_SERVO-1:0]     wr_servo_s;
    logic                     bcast_drive_s;
    logic                     bcast_rot_s;
    logic                     wr_global_s;
    logic                     wr_sticky_s;
    logic                     wr_mask_s;
    logic [NUM_M-1:0]         sticky_clr_s;
    logic [7:0]               rd_mux_s;
    logic                     halt_s;
    logic [8*NUM_DRIVE-1:0]   drive_gate_s;
    logic [3*NUM_ROT-1:0]     rot_gate_s;

    // Address decode for writes and the CURR_LO shadow-capture reads
    always_comb begin
        bcast_drive_s = bus.write_en &&
                        ((bus.address == ADDR_W'(1)) || (bus.address == ADDR_W'(3)));
        bcast_rot_s   = bus.write_en &&
                        ((bus.address == ADDR_W'(1)) || (bus.address == ADDR_W'(2)));
        wr_global_s   = bus.write_en && (bus.address == ADDR_W'(4));
        wr_sticky_s   = bus.write_en && (bus.address == ADDR_W'(5));
        wr_mask_s     = bus.write_en && (bus.address == ADDR_W'(6));
        wr_drive_s    = '0;
        wr_rot_ctrl_s = '0;
        wr_targ_s     = '0;
        rd_curr_lo_s  = '0;
        wr_servo_s    = '0;
        for (int d = 0; d < NUM_DRIVE; d++) begin
            wr_drive_s[d] = bus.write_en && (bus.address == ADDR_W'(8 + 2 * d));
        end
        for (int r = 0; r < NUM_ROT; r++) begin
            wr_rot_ctrl_s[r] = bus.write_en && (bus.address == ADDR_W'(RB + 4 * r));
            wr_targ_s[r]     = bus.write_en && (bus.address == ADDR_W'(RB + 4 * r + 1));
            rd_curr_lo_s[r]  = bus.read_en  && (bus.address == ADDR_W'(RB + 4 * r + 2));
        end
        for (int s = 0; s < NUM_SERVO; s++) begin
            wr_servo_s[s] = bus.write_en && (bus.address == ADDR_W'(SB + s));
        end
        sticky_clr_s = wr_sticky_s ? bus.wr_data[NUM_M-1:0] : '0;
    end

    // Read mux; mapped addresses are unique so the terms are OR-combined
    always_comb begin
        rd_mux_s = 8'h00;
        rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(0)}} & ID_VAL);
        rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(4)}} &
                               {5'b00000, wdog_tripped_r, estop_r, wdog_en_r});
        rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(5)}} & 8'(sticky_r));
        rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(6)}} & 8'(mask_r));
        for (int d = 0; d < NUM_DRIVE; d++) begin
            rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(8 + 2 * d)}} & drive_reg_r[d]);
            rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(9 + 2 * d)}} &
                                   {fault[d], adc_temp[7*d +: 7]});
        end
        for (int r = 0; r < NUM_ROT; r++) begin
            rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(RB + 4 * r)}} & rot_reg_r[r]);
            rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(RB + 4 * r + 1)}} &
                                   target_r[12*r +: 8]);
            rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(RB + 4 * r + 2)}} &
                                   current_angle[12*r +: 8]);
            rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(RB + 4 * r + 3)}} &
                                   {4'h0, shadow_r[r]});
        end
        for (int s = 0; s < NUM_SERVO; s++) begin
            rd_mux_s = rd_mux_s | ({8{bus.address == ADDR_W'(SB + s)}} & servo_r[8*s +: 8]);
        end
    end

    // Output gating: stored CTRL is untouched, only the driven copy is masked
    always_comb begin
        halt_s       = estop_r | wdog_tripped_r;
        drive_gate_s = '0;
        rot_gate_s   = '0;
        for (int d = 0; d < NUM_DRIVE; d++) begin
            drive_gate_s[8*d +: 8] = {drive_reg_r[d][7] | halt_s,
                                      drive_reg_r[d][6] & ~sticky_r[d] & ~halt_s,
                                      drive_reg_r[d][5:0]};
        end
        for (int r = 0; r < NUM_ROT; r++) begin
            rot_gate_s[3*r +: 3] = {rot_reg_r[r][7] | halt_s,
                                    rot_reg_r[r][6] & ~sticky_r[NUM_DRIVE + r] & ~halt_s,
                                    rot_reg_r[r][5]};
        end
    end

    // Control, target, shadow and servo registers
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int d = 0; d < NUM_DRIVE; d++) drive_reg_r[d] <= 8'h00;
            for (int r = 0; r < NUM_ROT; r++) begin
                rot_reg_r[r] <= 8'h00;
                shadow_r[r]  <= 4'h0;
            end
            target_r  <= '0;
            servo_r   <= '0;
            mask_r    <= '0;
            wdog_en_r <= 1'b0;
            estop_r   <= 1'b0;
        end else begin
            for (int d = 0; d < NUM_DRIVE; d++) begin
                if (wr_drive_s[d] || bcast_drive_s) drive_reg_r[d] <= bus.wr_data;
            end
            for (int r = 0; r < NUM_ROT; r++) begin
                // bit4 of rotation CTRL is reserved and always reads zero
                if (wr_rot_ctrl_s[r] || bcast_rot_s)
                    rot_reg_r[r] <= {bus.wr_data[7:5], 1'b0, bus.wr_data[3:0]};
                // Commit uses the high nibble already held in CTRL
                if (wr_targ_s[r])
                    target_r[12*r +: 12] <= {rot_reg_r[r][3:0], bus.wr_data};
                if (rd_curr_lo_s[r])
                    shadow_r[r] <= current_angle[12*r + 8 +: 4];
            end
            for (int s = 0; s < NUM_SERVO; s++) begin
                if (wr_servo_s[s]) servo_r[8*s +: 8] <= bus.wr_data;
            end
            if (wr_mask_s) mask_r <= bus.wr_data[NUM_M-1:0];
            if (wr_global_s) begin
                wdog_en_r <= bus.wr_data[0];
                estop_r   <= bus.wr_data[1];
            end
        end
    end

    // Host-link watchdog: any write restarts it, trip is cleared only by W1C
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt_r     <= '0;
            wdog_tripped_r <= 1'b0;
        end else if (bus.write_en) begin
            wdog_cnt_r <= '0;
            if (wr_global_s && bus.wr_data[2]) wdog_tripped_r <= 1'b0;
        end else if (!wdog_en_r) begin
            wdog_cnt_r <= '0;
        end else if (wdog_cnt_r == WDOG_MAX) begin
            wdog_tripped_r <= 1'b1;
        end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
        end
    end

    // Sticky faults (set beats clear), interrupt and gated control outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_r    <= '0;
            irq_r       <= 1'b0;
            drive_out_r <= '0;
            rot_out_r   <= '0;
        end else begin
            sticky_r    <= (sticky_r & ~sticky_clr_s) | fault;
            irq_r       <= (|(sticky_r & ~mask_r)) | wdog_tripped_r;
            drive_out_r <= drive_gate_s;
            rot_out_r   <= rot_gate_s;
        end
    end

    // Read port: one-cycle latency, data holds between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= bus.read_en;
            if (bus.read_en) rd_data_r <= rd_mux_s;
        end
    end

    assign bus.rd_data     = rd_data_r;
    assign bus.rd_valid    = rd_valid_r;
    assign drive_ctrl      = drive_out_r;
    assign rot_ctrl        = rot_out_r;
    assign target_angle    = target_r;
    assign servo_position  = servo_r;
    assign wdog_tripped    = wdog_tripped_r;
    assign irq             = irq_r;

endmodule

// File: tb/tb_motor_reg_file_gen2.sv
// Self-checking bench for motor_reg_file_gen2: directed scenarios followed by
// randomized bus traffic, all checked against a behavioural register model.
module tb_motor_reg_file_gen2;
    localparam int ND = 4, NR = 4, NS = 4, NM = 8, LIMIT = 16;
    localparam int RB = 8 + 2 * ND;
    localparam int SB = RB + 4 * NR;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    motor_reg_file_gen2_if #(.ADDR_W(7)) bus_if ();

    logic [NM-1:0]     fault;
    logic [7*NM-1:0]   adc_temp;
    logic [12*NR-1:0]  current_angle;
    logic [8*ND-1:0]   drive_ctrl;
    logic [3*NR-1:0]   rot_ctrl;
    logic [12*NR-1:0]  target_angle;
    logic [8*NS-1:0]   servo_position;
    logic              wdog_tripped;
    logic              irq;

    motor_reg_file_gen2 #(
        .NUM_DRIVE(ND), .NUM_ROT(NR), .NUM_SERVO(NS),
        .ADDR_W(7), .WDOG_W(24), .WDOG_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus_if),
        .fault(fault), .adc_temp(adc_temp), .current_angle(current_angle),
        .drive_ctrl(drive_ctrl), .rot_ctrl(rot_ctrl), .target_angle(target_angle),
        .servo_position(servo_position), .wdog_tripped(wdog_tripped), .irq(irq)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model of the register file contents
    logic [7:0]    m_drive [ND];
    logic [7:0]    m_rot   [NR];
    logic [7:0]    m_servo [NS];
    logic [11:0]   m_tgt   [NR];
    logic [3:0]    m_shadow[NR];
    logic [NM-1:0] m_sticky, m_mask;
    bit            m_en, m_estop, m_trip;
    int            m_idle;
    logic [7:0]    e_rd;
    bit            e_rv, e_irq;
    logic [31:0]   e_drive;
    logic [11:0]   e_rot;

    task automatic model_init();
        for (int i = 0; i < ND; i++) m_drive[i] = 8'h00;
        for (int i = 0; i < NS; i++) m_servo[i] = 8'h00;
        for (int i = 0; i < NR; i++) begin
            m_rot[i] = 8'h00; m_tgt[i] = 12'h000; m_shadow[i] = 4'h0;
        end
        m_sticky = '0; m_mask = '0; m_en = 0; m_estop = 0; m_trip = 0; m_idle = 0;
        e_rd = 8'h00; e_rv = 0; e_irq = 0; e_drive = '0; e_rot = '0;
    endtask

    function automatic logic [7:0] model_read(input int a);
        int k;
        if (a == 0) return 8'h44;
        if (a == 4) return {5'b00000, m_trip, m_estop, m_en};
        if (a == 5) return m_sticky;
        if (a == 6) return m_mask;
        if (a >= 8 && a < RB) begin
            k = (a - 8) / 2;
            if ((a - 8) % 2 == 0) return m_drive[k];
            return {fault[k], adc_temp[7*k +: 7]};
        end
        if (a >= RB && a < SB) begin
            k = (a - RB) / 4;
            case ((a - RB) % 4)
                0:       return m_rot[k];
                1:       return m_tgt[k][7:0];
                2:       return current_angle[12*k +: 8];
                default: return {4'h0, m_shadow[k]};
            endcase
        end
        if (a >= SB && a < SB + NS) return m_servo[a - SB];
        return 8'h00;
    endfunction

    task automatic model_write(input int a, input logic [7:0] d);
        if (a == 1 || a == 3) for (int i = 0; i < ND; i++) m_drive[i] = d;
        if (a == 1 || a == 2) for (int i = 0; i < NR; i++) m_rot[i] = d & 8'hEF;
        if (a == 4) begin
            m_en = d[0]; m_estop = d[1];
            if (d[2]) m_trip = 0;
        end
        if (a == 6) m_mask = d;
        if (a >= 8 && a < RB && (a - 8) % 2 == 0) m_drive[(a - 8) / 2] = d;
        if (a >= RB && a < SB && (a - RB) % 4 == 0) m_rot[(a - RB) / 4] = d & 8'hEF;
        if (a >= RB && a < SB && (a - RB) % 4 == 1)
            m_tgt[(a - RB) / 4] = {m_rot[(a - RB) / 4][3:0], d};
        if (a >= SB && a < SB + NS) m_servo[a - SB] = d;
    endtask

    task automatic compare_outputs();
        logic [47:0] tgt;
        logic [31:0] srv;
        for (int i = 0; i < NR; i++) tgt[12*i +: 12] = m_tgt[i];
        for (int i = 0; i < NS; i++) srv[8*i +: 8] = m_servo[i];
        check_value("rd_valid", bus_if.rd_valid, e_rv);
        check_value("rd_data", bus_if.rd_data, e_rd);
        check_value("drive_ctrl", drive_ctrl, e_drive);
        check_value("rot_ctrl", rot_ctrl, e_rot);
        check_value("target_angle", target_angle, tgt);
        check_value("servo_position", servo_position, srv);
        check_value("wdog_tripped", wdog_tripped, m_trip);
        check_value("irq", irq, e_irq);
    endtask

    // One bus cycle: drive inputs, advance the model, check after the edge
    task automatic step(input bit we, input int a, input logic [7:0] d, input bit re);
        bit halt;
        logic [7:0] clr;
        int r;
        @(negedge clock);
        bus_if.write_en = we;
        bus_if.address  = 7'(a);
        bus_if.wr_data  = d;
        bus_if.read_en  = re;
        halt = m_estop | m_trip;
        for (int i = 0; i < ND; i++)
            e_drive[8*i +: 8] = {m_drive[i][7] | halt, m_drive[i][6] & ~m_sticky[i] & ~halt,
                                 m_drive[i][5:0]};
        for (int i = 0; i < NR; i++)
            e_rot[3*i +: 3] = {m_rot[i][7] | halt, m_rot[i][6] & ~m_sticky[ND + i] & ~halt,
                               m_rot[i][5]};
        e_irq = (|(m_sticky & ~m_mask)) | m_trip;
        e_rv = re;
        if (re) e_rd = model_read(a);
        if (re && a >= RB && a < SB && (a - RB) % 4 == 2) begin
            r = (a - RB) / 4;
            m_shadow[r] = current_angle[12*r + 8 +: 4];
        end
        // Watchdog: count consecutive enabled write-free cycles, trip at LIMIT
        if (we) m_idle = 0;
        else if (!m_en) m_idle = 0;
        else if (m_idle < LIMIT) m_idle++;
        if (!we && m_idle == LIMIT) m_trip = 1;
        clr = (we && a == 5) ? d : 8'h00;
        m_sticky = (m_sticky & ~clr) | fault;
        if (we) model_write(a, d);
        @(posedge clock);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus_if.write_en = 1'b0; bus_if.read_en = 1'b0;
        bus_if.address = 7'h00; bus_if.wr_data = 8'h00;
        fault = '0; adc_temp = '0; current_angle = '0;
        model_init();
        repeat (2) @(posedge clock);
        #1;
        check_value("reset_rd_data", bus_if.rd_data, 8'h00);
        check_value("reset_rd_valid", bus_if.rd_valid, 1'b0);
        check_value("reset_drive_ctrl", drive_ctrl, 32'h0);
        check_value("reset_rot_ctrl", rot_ctrl, 12'h0);
        check_value("reset_target", target_angle, 48'h0);
        check_value("reset_wdog", wdog_tripped, 1'b0);
        check_value("reset_irq", irq, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // ID register
        step(0, 0, 8'h00, 1);
        check_value("id_read", bus_if.rd_data, 8'h44);
        check_value("id_valid", bus_if.rd_valid, 1'b1);

        // Rotation broadcast then target commit
        step(1, 2, 8'hC5, 0);
        step(0, RB, 8'h00, 1);
        check_value("rot_bcast", bus_if.rd_data, 8'hC5);
        step(0, 8, 8'h00, 1);
        check_value("drive_untouched", bus_if.rd_data, 8'h00);
        check_value("tgt_not_moved", target_angle, 48'h0);
        step(1, RB + 1, 8'h3A, 0);
        check_value("tgt_commit", target_angle[11:0], 12'h53A);

        // Atomic angle read
        current_angle[11:0] = 12'h7F2;
        step(0, RB + 2, 8'h00, 1);
        check_value("curr_lo", bus_if.rd_data, 8'hF2);
        current_angle[11:0] = 12'h8AB;
        step(0, RB + 3, 8'h00, 1);
        check_value("curr_hi_shadow", bus_if.rd_data, 8'h07);

        // Sticky fault gating and W1C, including set-wins
        step(1, 10, 8'h5F, 0);
        fault = 8'h02;
        idle(1);
        fault = 8'h00;
        idle(2);
        check_value("fault_gated_en", drive_ctrl[14], 1'b0);
        check_value("fault_irq", irq, 1'b1);
        step(1, 5, 8'h02, 0);
        idle(2);
        check_value("w1c_en_back", drive_ctrl[14], 1'b1);
        check_value("w1c_irq_low", irq, 1'b0);
        fault = 8'h02;
        step(1, 5, 8'h02, 0);
        fault = 8'h00;
        step(0, 5, 8'h00, 1);
        check_value("set_wins", bus_if.rd_data, 8'h02);
        step(1, 5, 8'hFF, 0);

        // Watchdog trip after LIMIT idle cycles, then W1C
        step(1, 4, 8'h01, 0);
        idle(LIMIT - 1);
        check_value("wdog_not_yet", wdog_tripped, 1'b0);
        idle(1);
        check_value("wdog_trip", wdog_tripped, 1'b1);
        idle(1);
        check_value("wdog_drive_brakes", drive_ctrl & 32'h80808080, 32'h80808080);
        check_value("wdog_rot_brakes", rot_ctrl & 12'b100100100100, 12'b100100100100);
        step(1, 4, 8'h05, 0);
        check_value("wdog_cleared", wdog_tripped, 1'b0);
        step(1, 4, 8'h00, 0);
        idle(1);
        check_value("wdog_restore", drive_ctrl[15:8], 8'h5F);

        // E-stop forces brakes and drops enables without touching CTRL
        step(1, 4, 8'h02, 0);
        idle(1);
        check_value("estop_drive1", drive_ctrl[15:8], 8'h9F);
        step(1, 4, 8'h00, 0);
        idle(1);
        check_value("estop_release", drive_ctrl[15:8], 8'h5F);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            int a;
            fault = ($urandom_range(0, 15) == 0) ? NM'(1 << $urandom_range(0, NM - 1)) : '0;
            adc_temp = {$urandom, $urandom};
            current_angle = {$urandom, $urandom};
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                            : int'($urandom_range(0, SB + NS + 3));
            step(bit'($urandom_range(0, 1)), a, 8'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
